timer_bank: RTL and testbench
=============================

# timer_bank

Parametrised multi-channel down-counting timer peripheral for the MIPS SoC, replacing the pair of fixed single-mode timer instances behind the bridge. It exposes a memory-mapped register window of `NUM_CH` identical channels and drives one level interrupt per channel into the CPU `HWInt` vector. Each channel adds three things to the current timers: a clock prescaler, a sticky pending bit cleared by writing 1 (W1C), and a per-channel interrupt mask.

## Interface
- `NUM_CH`, 2: number of channels (1..6).
- `CNT_W`, 32: counter/preset width (8..32); PRESET/COUNT bits above `CNT_W` read 0.
- `BASE`, 32'h0000_7F00: byte base address. Each channel owns 16 bytes at `BASE + 16*ch`.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `addr` in 32: bus byte address from the CPU data port.
- `we` in 1: write strobe, qualified internally by `hit`.
- `byteen` in 4: write byte enables.
- `wdata` in 32: write data.
- `hit` out 1: `addr` falls in `[BASE, BASE+16*NUM_CH)`; bridge uses it for read-mux select.
- `rdata` out 32: combinational read data.
- `irq` out NUM_CH: per-channel interrupt level, `PEND & IM`.

## Operation
- Per-channel registers, offsets within the 16-byte slot:
  - +0 CTRL (RW): [0] EN, [2:1] MODE, [3] IM, [15:8] PSC.
  - +4 PRESET (RW).
  - +8 COUNT (RO; writes ignored).
  - +C STATUS: [0] PEND; writing 1 clears, writing 0 has no effect.
- MODE 00 is one-shot and MODE 01 is auto-reload. MODE 1x is reserved and behaves as 00.
- Writes merge per byte under `byteen`. Unimplemented bits read 0. Reads of unmapped addresses, or addresses outside the window, return 0.
- Any write to CTRL clears PEND.
- Per-channel FSM:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; psc_cnt <= 0; go to CNT.
  - CNT:
    - If !EN, go to IDLE; COUNT holds.
    - Else if COUNT==0, go to INT and set PEND on the same edge.
    - Else if psc_cnt==PSC, COUNT -= 1 and psc_cnt <= 0.
    - Else psc_cnt += 1.
  - INT:
    - Mode 00: hardware clears EN and goes to IDLE.
    - Mode 01: go to LOAD if EN, else go to IDLE.
- Simultaneous events:
  - Hardware PEND set and a W1C in the same cycle: set wins.
  - Hardware EN clear (INT, mode 00) and a bus CTRL write in the same cycle: bus write wins.
  - A PRESET write during CNT does not affect the running count; it takes effect at the next LOAD.
- Writing PRESET=0 gives an INT on the first CNT cycle. Counting never wraps below 0.

## Timing
- Reset: all CTRL, PRESET, COUNT, PEND and psc_cnt are 0; every FSM is in IDLE; `irq`=0; `rdata`=0 (because the registers are 0).
- Register writes take effect at the `clk` edge on which `we & hit`. `rdata` reflects the current `addr` in the same cycle; there is no read latency.
- Timing from the CTRL write edge E0 (EN=1) to the PEND/irq rising edge is E0 + 3 + P*(PSC+1), where P is PRESET.
- The auto-reload period between successive INT entries is P*(PSC+1) + 3 cycles.
- Clearing EN stops the channel at the next edge.
- `reset` asserted mid-count forces the reset state immediately, independent of `clk`.

## Structure
- Shared package `timer_bank_pkg` holds:
  - FSM state enum: IDLE, LOAD, CNT, INT.
  - Register offset constants: OFF_CTRL, OFF_PRESET, OFF_COUNT, OFF_STATUS.
  - CTRL bit positions and widths.
  - Mode codes.
- Sub-module `timer_channel` contains one channel's registers, FSM and prescaler. `timer_bank` instantiates it `NUM_CH` times via generate and holds the address decode, per-channel write-enable fan-out and read mux.

## Test plan
- Reset, then read all 4*NUM_CH registers: every read returns 0, `irq`=0, `hit`=1 only inside the window.
- Ch0: PRESET=5, CTRL=0x9 (EN, one-shot, IM) written at edge E0: `irq[0]` rises at E0+8, EN reads 0 afterwards, COUNT reads 0, and `irq` stays high until STATUS is written with 0x1.
- Ch1: PRESET=3, PSC=2, mode 01, IM=1: first PEND at E0+12, then INT entered every 12 cycles. A W1C in the same cycle as a hardware set leaves PEND=1.
- Byte-enable write to PRESET with `byteen`=4'b0010 and `wdata`=32'hAABBCCDD: PRESET changes only in bits [15:8], to 0xCC. A write to COUNT leaves COUNT unchanged.
- Mid-count (COUNT=10): write CTRL EN=0 and verify COUNT freezes at the next edge. Re-enable and verify a reload from PRESET. Pulse `reset` mid-count and verify every channel is in IDLE with COUNT=0 without waiting for a `clk` edge.
- IM=0 with PEND set: `irq`=0 and STATUS reads 1. Setting IM=1 via a CTRL write clears PEND, so `irq` stays 0.

Source files
------------

// File: rtl/timer_bank_pkg.sv
// Shared definitions for the multi-channel timer bank: FSM states, register
// offsets, CTRL field layout and mode codes.
package timer_bank_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [3:0] OFF_CTRL   = 4'h0;
    localparam logic [3:0] OFF_PRESET = 4'h4;
    localparam logic [3:0] OFF_COUNT  = 4'h8;
    localparam logic [3:0] OFF_STATUS = 4'hC;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_W   = 2;
    localparam int CTRL_IM_BIT   = 3;
    localparam int CTRL_PSC_LSB  = 8;
    localparam int CTRL_PSC_W    = 8;

    // Only EN, MODE, IM and PSC exist; every other CTRL bit reads back 0.
    localparam logic [15:0] CTRL_MASK = 16'hFF0F;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[8*b +: 8] = be[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/timer_bank_channel.sv
// One timer channel: CTRL/PRESET/COUNT/STATUS registers, prescaler and the
// IDLE/LOAD/CNT/INT sequencer that produces a sticky, maskable interrupt.
module timer_channel
    import timer_bank_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [1:0]  word_sel,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    state_t                state_q, state_d;
    logic [15:0]           ctrl_q, ctrl_d;
    logic [CNT_W-1:0]      preset_q, preset_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [CTRL_PSC_W-1:0] psc_cnt_q, psc_cnt_d;
    logic                  pend_q, pend_d;

    logic                   en;
    logic                   im;
    logic [CTRL_MODE_W-1:0] mode;
    logic [CTRL_PSC_W-1:0]  psc;
    logic                   ctrl_wr;
    logic                   preset_wr;
    logic                   status_wr;
    logic                   hw_set_pend;
    logic                   hw_clr_en;
    logic [31:0]            wr_merged;

    assign en   = ctrl_q[CTRL_EN_BIT];
    assign im   = ctrl_q[CTRL_IM_BIT];
    assign mode = ctrl_q[CTRL_MODE_LSB +: CTRL_MODE_W];
    assign psc  = ctrl_q[CTRL_PSC_LSB +: CTRL_PSC_W];

    assign ctrl_wr   = wr_en && (word_sel == OFF_CTRL[3:2]);
    assign preset_wr = wr_en && (word_sel == OFF_PRESET[3:2]);
    assign status_wr = wr_en && (word_sel == OFF_STATUS[3:2]);

    // The addressed register's current read value is the base for byte merging.
    assign wr_merged = merge_bytes(rdata, wdata, byteen);

    assign irq = pend_q & im;

    always_comb begin
        rdata = '0;
        case (word_sel)
            OFF_CTRL[3:2]:   rdata = {16'h0000, ctrl_q};
            OFF_PRESET[3:2]: rdata = 32'(preset_q);
            OFF_COUNT[3:2]:  rdata = 32'(count_q);
            OFF_STATUS[3:2]: rdata = {31'd0, pend_q};
            default:         rdata = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        ctrl_d      = ctrl_q;
        preset_d    = preset_q;
        count_d     = count_q;
        psc_cnt_d   = psc_cnt_q;
        pend_d      = pend_q;
        hw_set_pend = 1'b0;
        hw_clr_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d   = preset_q;
                psc_cnt_d = '0;
                state_d   = CNT;
            end
            CNT: begin
                if (!en) begin
                    state_d = IDLE;
                end else if (count_q == '0) begin
                    state_d     = INT;
                    hw_set_pend = 1'b1;
                end else if (psc_cnt_q == psc) begin
                    count_d   = count_q - CNT_W'(1);
                    psc_cnt_d = '0;
                end else begin
                    psc_cnt_d = psc_cnt_q + CTRL_PSC_W'(1);
                end
            end
            INT: begin
                // Reserved modes fall into the one-shot branch.
                case (mode)
                    MODE_RELOAD: state_d = en ? LOAD : IDLE;
                    default: begin
                        hw_clr_en = 1'b1;
                        state_d   = IDLE;
                    end
                endcase
            end
            default: state_d = IDLE;
        endcase

        if (preset_wr) begin
            preset_d = wr_merged[CNT_W-1:0];
        end

        if (ctrl_wr) begin
            ctrl_d = wr_merged[15:0] & CTRL_MASK;
        end else if (hw_clr_en) begin
            ctrl_d[CTRL_EN_BIT] = 1'b0;
        end

        // A hardware set beats both the W1C and the CTRL-write clear.
        if (hw_set_pend) begin
            pend_d = 1'b1;
        end else if (ctrl_wr || (status_wr && byteen[0] && wdata[0])) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            ctrl_q    <= '0;
            preset_q  <= '0;
            count_q   <= '0;
            psc_cnt_q <= '0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            psc_cnt_q <= psc_cnt_d;
            pend_q    <= pend_d;
        end
    end

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of NUM_CH timer channels: window decode, per-channel
// write strobes, combinational read mux and per-channel interrupt levels.
module timer_bank
    import timer_bank_pkg::*;
#(
    parameter int          NUM_CH = 2,
    parameter int          CNT_W  = 32,
    parameter logic [31:0] BASE   = 32'h0000_7F00
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic              we,
    input  logic [3:0]        byteen,
    input  logic [31:0]       wdata,
    output logic              hit,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq
);

    localparam logic [32:0] WIN_END = {1'b0, BASE} + 33'(16 * NUM_CH);

    logic [27:0]       slot_idx;
    logic [1:0]        word_sel;
    logic [NUM_CH-1:0] ch_wr;
    logic [31:0]       ch_rdata [NUM_CH];

    // BASE is 16-byte aligned, so the slot index is a plain upper-bit difference.
    assign slot_idx = addr[31:4] - BASE[31:4];
    assign word_sel = addr[3:2];
    assign hit      = (addr >= BASE) && ({1'b0, addr} < WIN_END);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign ch_wr[g] = we && hit && (slot_idx == 28'(g));

        timer_channel #(
            .CNT_W(CNT_W)
        ) u_channel (
            .clk     (clk),
            .reset   (reset),
            .wr_en   (ch_wr[g]),
            .word_sel(word_sel),
            .byteen  (byteen),
            .wdata   (wdata),
            .rdata   (ch_rdata[g]),
            .irq     (irq[g])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (hit && (slot_idx == 28'(i))) begin
                rdata = ch_rdata[i];
            end
        end
    end

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: register table, hand-written timing
// sequences and randomized channel configurations against an arithmetic model.
module tb_timer_bank;

    localparam int          NUM_CH = 2;
    localparam logic [31:0] BASE   = 32'h0000_7F00;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       addr = '0;
    logic              we = 1'b0;
    logic [3:0]        byteen = '0;
    logic [31:0]       wdata = '0;
    logic              hit;
    logic [31:0]       rdata;
    logic [NUM_CH-1:0] irq;

    int tests_run    = 0;
    int tests_failed = 0;
    int edge_n       = 0;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        exp_hit;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[$];

    timer_bank #(
        .NUM_CH(NUM_CH),
        .CNT_W (32),
        .BASE  (BASE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .byteen(byteen),
        .wdata (wdata),
        .hit   (hit),
        .rdata (rdata),
        .irq   (irq)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] reg_addr(input int ch, input int off);
        return BASE + 32'(16 * ch + off);
    endfunction

    function automatic logic [31:0] ctrl_word(input int psc, input int im,
                                              input int mode, input int en);
        return (32'(psc) << 8) | (32'(im) << 3) | (32'(mode) << 1) | 32'(en);
    endfunction

    // Reference model: CTRL write at edge e0, first load two edges later,
    // each count step lasts psc+1 edges, reload period is span+3.
    function automatic int model_count(input int t, input int e0, input int p,
                                       input int psc, input bit reload);
        int l0, span, d;
        l0   = e0 + 2;
        span = p * (psc + 1);
        if (t < l0) return 0;
        d = t - l0;
        if (reload) d = d % (span + 3);
        if (d >= span) return 0;
        return p - d / (psc + 1);
    endfunction

    function automatic bit model_pend(input int t, input int e0, input int p, input int psc);
        return t >= e0 + 3 + p * (psc + 1);
    endfunction

    function automatic bit model_en(input int t, input int e0, input int p,
                                    input int psc, input bit reload);
        if (reload) return 1'b1;
        return t < e0 + 4 + p * (psc + 1);
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic w,
                                 input logic [3:0] be, input logic [31:0] d);
        addr   = a;
        we     = w;
        byteen = be;
        wdata  = d;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        #1;
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        applyStimulus(a, 1'b1, be, d);
        tick();
        applyStimulus(a, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic readReg(input logic [31:0] a, output logic [31:0] d);
        applyStimulus(a, 1'b0, 4'h0, 32'h0);
        #1;
        d = rdata;
    endtask

    task automatic doReset();
        applyStimulus(BASE, 1'b0, 4'h0, 32'h0);
        reset = 1'b1;
        #3;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] rd;
        int          e0;
        int          e1;
        int          r;
        bit          pend;

        // ---------------- table-driven register/decode checks ----------------
        for (int c = 0; c < NUM_CH; c++) begin
            for (int o = 0; o < 16; o += 4) begin
                vecs.push_back('{$sformatf("rst_ch%0d_off%0d", c, o), reg_addr(c, o),
                                 1'b0, 4'h0, 32'h0, 1'b1, 32'h0});
            end
        end
        vecs.push_back('{"below_win",   32'h0000_7EFC, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{"above_win",   32'h0000_7F20, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{"zero_addr",   32'h0000_0000, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{"alias_addr",  32'hFFFF_7F00, 1'b0, 4'h0, 32'h0, 1'b0, 32'h0});
        vecs.push_back('{"be_preset",   reg_addr(0, 4), 1'b1, 4'b0010, 32'hAABB_CCDD, 1'b1, 32'h0});
        vecs.push_back('{"preset_rd",   reg_addr(0, 4), 1'b0, 4'h0, 32'h0, 1'b1, 32'h0000_CC00});
        vecs.push_back('{"count_wr",    reg_addr(0, 8), 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0});
        vecs.push_back('{"count_rd",    reg_addr(0, 8), 1'b0, 4'h0, 32'h0, 1'b1, 32'h0});
        vecs.push_back('{"preset1_wr",  reg_addr(1, 4), 1'b1, 4'hF, 32'h1234_5678, 1'b1, 32'h0});
        vecs.push_back('{"preset1_rd",  reg_addr(1, 4), 1'b0, 4'h0, 32'h0, 1'b1, 32'h1234_5678});
        vecs.push_back('{"ctrl1_wr",    reg_addr(1, 0), 1'b1, 4'hF, 32'hFFFF_FFF0, 1'b1, 32'h0});
        vecs.push_back('{"ctrl1_rd",    reg_addr(1, 0), 1'b0, 4'h0, 32'h0, 1'b1, 32'h0000_FF00});
        vecs.push_back('{"ctrl1_b0",    reg_addr(1, 0), 1'b1, 4'b0001, 32'hFFFF_FF06, 1'b1, 32'h0000_FF00});
        vecs.push_back('{"ctrl1_rd2",   reg_addr(1, 0), 1'b0, 4'h0, 32'h0, 1'b1, 32'h0000_FF06});
        vecs.push_back('{"status1_rd",  reg_addr(1, 12), 1'b0, 4'h0, 32'h0, 1'b1, 32'h0});
        vecs.push_back('{"oob_wr",      32'h0000_7F20, 1'b1, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0});
        vecs.push_back('{"ctrl0_rd",    reg_addr(0, 0), 1'b0, 4'h0, 32'h0, 1'b1, 32'h0});

        doReset();
        checkOutput("rst_irq", 32'(irq), 32'h0);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].addr, vecs[i].we, vecs[i].be, vecs[i].wdata);
            #1;
            checkOutput({vecs[i].name, "_hit"}, 32'(hit), 32'(vecs[i].exp_hit));
            checkOutput({vecs[i].name, "_rdata"}, rdata, vecs[i].exp_rdata);
            tick();
            applyStimulus(vecs[i].addr, 1'b0, 4'h0, 32'h0);
        end

        // ---------------- one-shot ch0: PRESET=5, CTRL=0x9 ----------------
        doReset();
        writeReg(reg_addr(0, 4), 4'hF, 32'd5);
        writeReg(reg_addr(0, 0), 4'hF, 32'h9);
        e0 = edge_n;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checkOutput($sformatf("os_irq_e%0d", edge_n - e0), 32'(irq[0]), 32'(k >= 8));
        end
        readReg(reg_addr(0, 0), rd);
        checkOutput("os_ctrl_en_cleared", rd, 32'h8);
        readReg(reg_addr(0, 8), rd);
        checkOutput("os_count_zero", rd, 32'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("os_irq_hold", 32'(irq[0]), 32'h1);
        end
        writeReg(reg_addr(0, 12), 4'hF, 32'h0);
        checkOutput("os_w0_noclear", 32'(irq[0]), 32'h1);
        writeReg(reg_addr(0, 12), 4'hF, 32'h1);
        checkOutput("os_w1c_irq", 32'(irq[0]), 32'h0);
        readReg(reg_addr(0, 12), rd);
        checkOutput("os_w1c_status", rd, 32'h0);

        // ---------------- auto-reload ch1: P=3, PSC=2, W1C collisions ----------------
        doReset();
        writeReg(reg_addr(1, 4), 4'hF, 32'd3);
        writeReg(reg_addr(1, 0), 4'hF, ctrl_word(2, 1, 1, 1));
        e0   = edge_n;
        pend = 1'b0;
        for (int k = 1; k <= 37; k++) begin
            bit w1c;
            w1c = (k == 18) || (k == 24) || (k == 26);
            applyStimulus(reg_addr(1, 12), w1c, 4'hF, 32'h1);
            tick();
            applyStimulus(reg_addr(1, 12), 1'b0, 4'h0, 32'h0);
            if (k == 12 || k == 24 || k == 36) pend = 1'b1;
            else if (w1c) pend = 1'b0;
            checkOutput($sformatf("ar_irq_e%0d", k), 32'(irq[1]), 32'(pend));
        end
        checkOutput("ar_ch0_quiet", 32'(irq[0]), 32'h0);

        // ---------------- freeze, reload from PRESET, async reset ----------------
        doReset();
        writeReg(reg_addr(1, 4), 4'hF, 32'd50);
        writeReg(reg_addr(1, 0), 4'hF, 32'h9);
        e1 = edge_n;
        writeReg(reg_addr(0, 4), 4'hF, 32'd20);
        writeReg(reg_addr(0, 0), 4'hF, 32'h9);
        e0 = edge_n;
        for (int k = 0; k < 12; k++) tick();
        readReg(reg_addr(0, 8), rd);
        checkOutput("mid_count10", rd, 32'd10);
        writeReg(reg_addr(0, 0), 4'hF, 32'h8);
        readReg(reg_addr(0, 8), rd);
        checkOutput("stop_edge_count", rd, 32'd9);
        for (int k = 0; k < 4; k++) begin
            tick();
            readReg(reg_addr(0, 8), rd);
            checkOutput($sformatf("frozen_%0d", k), rd, 32'd9);
        end
        writeReg(reg_addr(0, 4), 4'hF, 32'd15);
        writeReg(reg_addr(0, 0), 4'hF, 32'h9);
        readReg(reg_addr(0, 8), rd);
        checkOutput("reen_r0", rd, 32'd9);
        tick();
        readReg(reg_addr(0, 8), rd);
        checkOutput("reen_r1", rd, 32'd9);
        tick();
        readReg(reg_addr(0, 8), rd);
        checkOutput("reen_reload", rd, 32'd15);
        writeReg(reg_addr(0, 4), 4'hF, 32'd3);
        readReg(reg_addr(0, 8), rd);
        checkOutput("preset_wr_running", rd, 32'd14);
        for (int k = 0; k < 3; k++) tick();
        readReg(reg_addr(0, 8), rd);
        checkOutput("preset_no_effect", rd, 32'd11);
        readReg(reg_addr(1, 8), rd);
        checkOutput("ch1_running", rd, 32'(50 - (edge_n - (e1 + 2))));
        reset = 1'b1;
        readReg(reg_addr(0, 8), rd);
        checkOutput("async_rst_count0", rd, 32'h0);
        readReg(reg_addr(1, 8), rd);
        checkOutput("async_rst_count1", rd, 32'h0);
        readReg(reg_addr(0, 0), rd);
        checkOutput("async_rst_ctrl0", rd, 32'h0);
        readReg(reg_addr(1, 4), rd);
        checkOutput("async_rst_preset1", rd, 32'h0);
        checkOutput("async_rst_irq", 32'(irq), 32'h0);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        readReg(reg_addr(0, 8), rd);
        checkOutput("post_rst_idle0", rd, 32'h0);
        readReg(reg_addr(1, 8), rd);
        checkOutput("post_rst_idle1", rd, 32'h0);

        // ---------------- masked pending, CTRL write clears PEND ----------------
        doReset();
        writeReg(reg_addr(0, 4), 4'hF, 32'd0);
        writeReg(reg_addr(0, 0), 4'hF, 32'h1);
        for (int k = 0; k < 4; k++) tick();
        checkOutput("mask_irq", 32'(irq[0]), 32'h0);
        readReg(reg_addr(0, 12), rd);
        checkOutput("mask_status", rd, 32'h1);
        writeReg(reg_addr(0, 0), 4'hF, 32'h8);
        checkOutput("unmask_irq", 32'(irq[0]), 32'h0);
        readReg(reg_addr(0, 12), rd);
        checkOutput("unmask_status", rd, 32'h0);
        readReg(reg_addr(0, 0), rd);
        checkOutput("unmask_ctrl", rd, 32'h8);

        // ---------------- randomized configurations vs. model ----------------
        for (r = 0; r < 20; r++) begin
            int p[NUM_CH];
            int psc[NUM_CH];
            int mode[NUM_CH];
            int im[NUM_CH];
            int st[NUM_CH];
            doReset();
            for (int c = 0; c < NUM_CH; c++) begin
                p[c]    = int'($urandom_range(0, 7));
                psc[c]  = int'($urandom_range(0, 3));
                mode[c] = int'($urandom_range(0, 3));
                im[c]   = int'($urandom_range(0, 1));
                writeReg(reg_addr(c, 4), 4'hF, 32'(p[c]));
            end
            for (int c = 0; c < NUM_CH; c++) begin
                writeReg(reg_addr(c, 0), 4'hF, ctrl_word(psc[c], im[c], mode[c], 1));
                st[c] = edge_n;
            end
            for (int k = 0; k < 60; k++) begin
                tick();
                for (int c = 0; c < NUM_CH; c++) begin
                    bit rl;
                    bit pd;
                    rl = (mode[c] == 1);
                    pd = model_pend(edge_n, st[c], p[c], psc[c]);
                    checkOutput($sformatf("rnd%0d_ch%0d_irq", r, c), 32'(irq[c]),
                                32'(pd & (im[c] != 0)));
                    readReg(reg_addr(c, 8), rd);
                    checkOutput($sformatf("rnd%0d_ch%0d_count", r, c), rd,
                                32'(model_count(edge_n, st[c], p[c], psc[c], rl)));
                    readReg(reg_addr(c, 12), rd);
                    checkOutput($sformatf("rnd%0d_ch%0d_status", r, c), rd, 32'(pd));
                    readReg(reg_addr(c, 0), rd);
                    checkOutput($sformatf("rnd%0d_ch%0d_ctrl", r, c), rd,
                                ctrl_word(psc[c], im[c], mode[c],
                                          int'(model_en(edge_n, st[c], p[c], psc[c], rl))));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
